mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between two requesters: the instruction-fetch port and the load/store port driven by the mem stage.
- Grants one requester at a time and holds the latched request on the bus until the bus acknowledges, then returns read data with a one-cycle ready pulse.
- Generates the pipeline stall request used by ctrl while any access is outstanding.
- Includes an acknowledge timeout so a dead bus cannot hang the core.

Parameters:
- TIMEOUT, 15: max cycles in an access state without bus_ack_i before abort; 0 disables the timeout.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_ce_i  in  1  fetch request, held until if_ready_o
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched instruction, registered
- if_ready_o  out  1  one-cycle fetch completion pulse
- mem_ce_i  in  1  load/store request, held until mem_ready_o
- mem_we_i  in  1  1 = store
- mem_addr_i  in  32  load/store address
- mem_sel_i  in  4  byte enables
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data (raw word), registered
- mem_ready_o  out  1  one-cycle load/store completion pulse
- bus_req_o  out  1  bus request, held until ack or abort
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  32  bus address
- bus_sel_o  out  4  bus byte enables
- bus_wdata_o  out  32  bus write data
- bus_rdata_i  in  32  bus read data, valid with ack
- bus_ack_i  in  1  bus completion
- stall_req_o  out  1  pipeline stall request
- err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE; last_gnt = IF; counter = 0; all outputs 0.
  - Any in-flight bus transaction is dropped.
  - No ready pulse is issued for a transaction dropped by reset.
- States: IDLE, IF_ACC, MEM_ACC. All bus_* outputs are registers.
- IDLE, grant on clock edge:
  - Only mem_ce_i pending → MEM_ACC.
  - Only if_ce_i pending → IF_ACC.
  - Both pending → round-robin: grant the requester not equal to last_gnt. last_gnt resets to IF, so the first contention goes to MEM.
  - On grant: latch addr/sel/we/wdata into bus_* and set bus_req_o = 1.
  - IF grants drive bus_we_o = 0, bus_sel_o = 4'b1111, bus_wdata_o = 0.
  - Update last_gnt; clear the counter.
- In IF_ACC / MEM_ACC:
  - bus_* outputs held stable; counter increments each cycle.
  - On bus_ack_i: capture bus_rdata_i into if_data_o or mem_data_o (for stores too); pulse that requester's ready for the next cycle; bus_req_o = 0; → IDLE.
- Latency: request sampled at edge N; bus_req_o = 1 in cycle N+1. With ack in cycle N+1, ready is high in cycle N+2.
  - Each access costs at least 2 cycles.
  - A new grant happens no earlier than the edge that raises ready, so bus_req_o is low for at least one cycle between accesses.
- Timeout: TIMEOUT ≠ 0 and counter reaches TIMEOUT with no ack:
  - bus_req_o = 0; → IDLE.
  - Pulse err_o and the owner's ready for one cycle, with that requester's data register forced to 0.
  - If ack arrives in the same cycle the counter hits TIMEOUT, ack wins: normal completion, no err_o.
- Ignored events:
  - bus_ack_i while in IDLE (late ack after abort/reset).
  - A requester dropping ce mid-access: the access still completes and the ready still pulses.
- Data outputs hold their last value until the next completion for that requester.
- stall_req_o, combinational: (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o).

Test Plan:
- Fetch only: if_ce_i = 1, addr 0x0000_0100, ack one cycle after bus_req_o rises, rdata 0x0000_0013 → bus_sel_o = 1111, bus_we_o = 0; if_ready_o pulses once with if_data_o = 0x0000_0013; stall_req_o is low in the ready cycle.
- Store: mem_ce_i = 1, we = 1, addr 0x0000_2002, sel 1100, data 0xBEEF_BEEF, ack after 3 wait cycles → bus_* stable for all 4 cycles; mem_ready_o pulses once; stall_req_o is high until the pulse.
- Contention: if_ce_i and mem_ce_i both asserted from reset, immediate acks → grant order MEM, IF, MEM, IF; each ready pulses on alternate accesses.
- Timeout: TIMEOUT = 15, fetch with no ack → bus_req_o drops after 15 cycles; err_o and if_ready_o pulse together with if_data_o = 0; a later stray ack in IDLE causes no pulse.
- Ack/timeout tie: ack arrives exactly at counter = 15 → normal completion with rdata captured; err_o stays 0.
- Reset mid-access: assert rst low during MEM_ACC → all outputs 0 immediately (asynchronous); no mem_ready_o after release; the next request is granted normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester, external bus and status signals of the memory bus arbiter.
// The arbiter side uses the master modport; the surrounding pipeline/bus model uses slave.
interface mem_bus_arbiter_if;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;

    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    logic        stall_req_o;
    logic        err_o;

    modport master (
        input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
               bus_rdata_i, bus_ack_i,
        output if_data_o, if_ready_o, mem_data_o, mem_ready_o,
               bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
               stall_req_o, err_o
    );

    modport slave (
        output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
               bus_rdata_i, bus_ack_i,
        input  if_data_o, if_ready_o, mem_data_o, mem_ready_o,
               bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
               stall_req_o, err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter for the single external memory bus,
// with round-robin contention, registered bus outputs and an acknowledge timeout.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;
    typedef enum logic {GNT_IF, GNT_MEM} gnt_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    gnt_t             last_gnt;
    logic [CNT_W-1:0] cnt;
    logic             grant_mem;
    logic             grant_if;
    logic             timed_out;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        grant_mem = bus.mem_ce_i && (!bus.if_ce_i || (last_gnt == GNT_IF));
        grant_if  = bus.if_ce_i && !grant_mem;
    end

    assign timed_out = (TIMEOUT != 0) && (cnt == TIMEOUT_CNT);

    assign bus.stall_req_o = (bus.if_ce_i & ~bus.if_ready_o) | (bus.mem_ce_i & ~bus.mem_ready_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            last_gnt        <= GNT_IF;
            cnt             <= '0;
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_sel_o   <= '0;
            bus.bus_wdata_o <= '0;
            bus.if_data_o   <= '0;
            bus.if_ready_o  <= 1'b0;
            bus.mem_data_o  <= '0;
            bus.mem_ready_o <= 1'b0;
            bus.err_o       <= 1'b0;
        end else begin
            bus.if_ready_o  <= 1'b0;
            bus.mem_ready_o <= 1'b0;
            bus.err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_mem) begin
                        state           <= MEM_ACC;
                        last_gnt        <= GNT_MEM;
                        bus.bus_req_o   <= 1'b1;
                        bus.bus_we_o    <= bus.mem_we_i;
                        bus.bus_addr_o  <= bus.mem_addr_i;
                        bus.bus_sel_o   <= bus.mem_sel_i;
                        bus.bus_wdata_o <= bus.mem_data_i;
                    end else if (grant_if) begin
                        state           <= IF_ACC;
                        last_gnt        <= GNT_IF;
                        bus.bus_req_o   <= 1'b1;
                        bus.bus_we_o    <= 1'b0;
                        bus.bus_addr_o  <= bus.if_addr_i;
                        bus.bus_sel_o   <= 4'b1111;
                        bus.bus_wdata_o <= '0;
                    end
                end
                IF_ACC, MEM_ACC: begin
                    cnt <= cnt + 1'b1;
                    // An ack in the timeout cycle still completes normally.
                    if (bus.bus_ack_i) begin
                        if (state == IF_ACC) begin
                            bus.if_data_o  <= bus.bus_rdata_i;
                            bus.if_ready_o <= 1'b1;
                        end else begin
                            bus.mem_data_o  <= bus.bus_rdata_i;
                            bus.mem_ready_o <= 1'b1;
                        end
                        bus.bus_req_o <= 1'b0;
                        state         <= IDLE;
                    end else if (timed_out) begin
                        if (state == IF_ACC) begin
                            bus.if_data_o  <= '0;
                            bus.if_ready_o <= 1'b1;
                        end else begin
                            bus.mem_data_o  <= '0;
                            bus.mem_ready_o <= 1'b1;
                        end
                        bus.err_o     <= 1'b1;
                        bus.bus_req_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: transaction-level requesters, a random-latency
// bus slave predicting grant order and completions, and a monitor popping expected responses.
module tb_mem_bus_arbiter;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = -1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_bus_arbiter_if mbi();

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(mbi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } resp_t;

    resp_t       if_q[$];
    resp_t       mem_q[$];
    int          delay_q[$];
    logic [31:0] rdata_q[$];
    int          grant_log[$];   // 0 = fetch, 1 = load/store

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit stray_force = 1'b0;

    // Reference model of the bus side
    bit          in_acc     = 1'b0;
    bit          just_done  = 1'b0;
    int          owner      = 0;
    int          last_owner = 0;
    int          wcnt       = 0;
    int          delay      = 0;
    logic        snap_if    = 1'b0;
    logic        snap_mem   = 1'b0;
    logic [31:0] snap_if_addr, snap_mem_addr, snap_mem_wdata;
    logic        snap_mem_we;
    logic [3:0]  snap_mem_sel;
    logic [31:0] e_addr, e_wdata;
    logic        e_we;
    logic [3:0]  e_sel;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus slave and grant predictor
    initial begin
        logic exp_req;
        mbi.bus_ack_i   = 1'b0;
        mbi.bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_acc = 0; just_done = 0; last_owner = 0;
                snap_if = 0; snap_mem = 0;
                mbi.bus_ack_i = 1'b0;
                continue;
            end
            if (!in_acc) begin
                exp_req = !just_done && (snap_if || snap_mem);
                chk("bus_req_idle", mbi.bus_req_o, exp_req);
                just_done = 0;
                if (exp_req && mbi.bus_req_o) begin
                    owner = (snap_if && snap_mem) ? 1 - last_owner : (snap_mem ? 1 : 0);
                    last_owner = owner;
                    grant_log.push_back(owner);
                    if (owner == 1) begin
                        e_addr = snap_mem_addr; e_we = snap_mem_we;
                        e_sel = snap_mem_sel;   e_wdata = snap_mem_wdata;
                    end else begin
                        e_addr = snap_if_addr; e_we = 1'b0; e_sel = 4'hf; e_wdata = '0;
                    end
                    in_acc = 1; wcnt = 0;
                    if (delay_q.size() > 0) delay = delay_q.pop_front();
                    else delay = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 3));
                end
            end else begin
                chk("bus_req_hold", mbi.bus_req_o, 1);
            end
            if (in_acc) begin
                chk("bus_addr", mbi.bus_addr_o, e_addr);
                chk("bus_we", mbi.bus_we_o, e_we);
                chk("bus_sel", mbi.bus_sel_o, e_sel);
                chk("bus_wdata", mbi.bus_wdata_o, e_wdata);
                if (wcnt == delay) begin
                    mbi.bus_ack_i   = 1'b1;
                    mbi.bus_rdata_i = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
                    if (owner == 1) mem_q.push_back('{mbi.bus_rdata_i, 1'b0, cyc + 1});
                    else            if_q.push_back('{mbi.bus_rdata_i, 1'b0, cyc + 1});
                    in_acc = 0; just_done = 1;
                end else if (wcnt == TIMEOUT) begin
                    mbi.bus_ack_i = 1'b0;
                    if (owner == 1) mem_q.push_back('{32'h0, 1'b1, cyc + 1});
                    else            if_q.push_back('{32'h0, 1'b1, cyc + 1});
                    in_acc = 0; just_done = 1;
                end else begin
                    mbi.bus_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                mbi.bus_ack_i   = stray_force || ($urandom_range(0, 3) == 0);
                mbi.bus_rdata_i = $urandom;
            end
            snap_if        = mbi.if_ce_i;
            snap_mem       = mbi.mem_ce_i;
            snap_if_addr   = mbi.if_addr_i;
            snap_mem_addr  = mbi.mem_addr_i;
            snap_mem_we    = mbi.mem_we_i;
            snap_mem_sel   = mbi.mem_sel_i;
            snap_mem_wdata = mbi.mem_data_i;
        end
    end

    // Completion monitor
    initial begin
        resp_t       r;
        logic [31:0] if_last, mem_last;
        bit          exp_if_rdy, exp_mem_rdy, exp_err;
        if_last = '0;
        mem_last = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if_q.delete(); mem_q.delete();
                if_last = '0; mem_last = '0;
                continue;
            end
            while (if_q.size() > 0 && if_q[0].due < cyc) begin
                fail("if_ready_missing", $sformatf("got no pulse, expected one in cycle %0d", if_q[0].due));
                void'(if_q.pop_front());
            end
            while (mem_q.size() > 0 && mem_q[0].due < cyc) begin
                fail("mem_ready_missing", $sformatf("got no pulse, expected one in cycle %0d", mem_q[0].due));
                void'(mem_q.pop_front());
            end
            exp_if_rdy  = (if_q.size() > 0) && (if_q[0].due == cyc);
            exp_mem_rdy = (mem_q.size() > 0) && (mem_q[0].due == cyc);
            exp_err     = 1'b0;
            chk("if_ready", mbi.if_ready_o, exp_if_rdy);
            chk("mem_ready", mbi.mem_ready_o, exp_mem_rdy);
            if (exp_if_rdy) begin
                r = if_q.pop_front();
                if_last = r.data;
                exp_err |= r.err;
            end
            if (exp_mem_rdy) begin
                r = mem_q.pop_front();
                mem_last = r.data;
                exp_err |= r.err;
            end
            chk("if_data", mbi.if_data_o, if_last);
            chk("mem_data", mbi.mem_data_o, mem_last);
            chk("err", mbi.err_o, exp_err);
            chk("stall", mbi.stall_req_o,
                (mbi.if_ce_i & ~exp_if_rdy) | (mbi.mem_ce_i & ~exp_mem_rdy));
        end
    end

    task automatic if_txn(input logic [31:0] a, input bit drop);
        int n;
        n = 0;
        mbi.if_ce_i = 1'b1;
        mbi.if_addr_i = a;
        while (n < 200) begin
            tick();
            n++;
            if (mbi.if_ready_o) break;
            if (drop && in_acc && owner == 0) mbi.if_ce_i = 1'b0;
        end
        if (!mbi.if_ready_o) fail("if_txn_wait", "got no if_ready_o, expected one within 200 cycles");
        mbi.if_ce_i = 1'b0;
    endtask

    task automatic mem_txn(input logic we, input logic [31:0] a, input logic [3:0] sel,
                           input logic [31:0] d, input bit drop);
        int n;
        n = 0;
        mbi.mem_ce_i = 1'b1;
        mbi.mem_we_i = we;
        mbi.mem_addr_i = a;
        mbi.mem_sel_i = sel;
        mbi.mem_data_i = d;
        while (n < 200) begin
            tick();
            n++;
            if (mbi.mem_ready_o) break;
            if (drop && in_acc && owner == 1) mbi.mem_ce_i = 1'b0;
        end
        if (!mbi.mem_ready_o) fail("mem_txn_wait", "got no mem_ready_o, expected one within 200 cycles");
        mbi.mem_ce_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_req"}, mbi.bus_req_o, 0);
        chk({tag, "_bus_we"}, mbi.bus_we_o, 0);
        chk({tag, "_bus_addr"}, mbi.bus_addr_o, 0);
        chk({tag, "_bus_sel"}, mbi.bus_sel_o, 0);
        chk({tag, "_bus_wdata"}, mbi.bus_wdata_o, 0);
        chk({tag, "_if_data"}, mbi.if_data_o, 0);
        chk({tag, "_mem_data"}, mbi.mem_data_o, 0);
        chk({tag, "_if_ready"}, mbi.if_ready_o, 0);
        chk({tag, "_mem_ready"}, mbi.mem_ready_o, 0);
        chk({tag, "_err"}, mbi.err_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected finish before 900000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mbi.if_ce_i = 0; mbi.if_addr_i = 0;
        mbi.mem_ce_i = 0; mbi.mem_we_i = 0; mbi.mem_addr_i = 0;
        mbi.mem_sel_i = 0; mbi.mem_data_i = 0;
        rst = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        // Contention straight out of reset, immediate acks
        grant_log.delete();
        delay_q = '{0, 0, 0, 0};
        rst = 1'b1;
        fork
            for (int i = 0; i < 2; i++) if_txn(32'h0000_1000 + 32'(i * 4), 1'b0);
            for (int j = 0; j < 2; j++) mem_txn(1'b0, 32'h0000_3000 + 32'(j * 4), 4'hf, 32'h0, 1'b0);
        join
        if (grant_log.size() != 4) chk("contention_grants", grant_log.size(), 4);
        else begin
            chk("grant0", grant_log[0], 1);
            chk("grant1", grant_log[1], 0);
            chk("grant2", grant_log[2], 1);
            chk("grant3", grant_log[3], 0);
        end
        repeat (2) tick();

        // Fetch only
        delay_q.push_back(1);
        rdata_q.push_back(32'h0000_0013);
        if_txn(32'h0000_0100, 1'b0);
        chk("fetch_data", mbi.if_data_o, 32'h0000_0013);
        chk("fetch_stall", mbi.stall_req_o, 0);
        repeat (2) tick();

        // Store with three wait cycles
        delay_q.push_back(3);
        mem_txn(1'b1, 32'h0000_2002, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        repeat (2) tick();

        // Timeout, then stray acks while idle
        delay_q.push_back(NEVER);
        if_txn(32'h0000_0200, 1'b0);
        chk("timeout_err", mbi.err_o, 1);
        chk("timeout_data", mbi.if_data_o, 0);
        stray_force = 1'b1;
        repeat (6) tick();
        stray_force = 1'b0;

        // Ack in the same cycle the counter reaches the limit
        delay_q.push_back(TIMEOUT);
        rdata_q.push_back(32'hCAFE_0001);
        if_txn(32'h0000_0300, 1'b0);
        chk("tie_err", mbi.err_o, 0);
        chk("tie_data", mbi.if_data_o, 32'hCAFE_0001);
        repeat (2) tick();

        // Asynchronous reset in the middle of a load/store access
        delay_q.push_back(NEVER);
        mbi.mem_ce_i = 1'b1; mbi.mem_we_i = 1'b1; mbi.mem_addr_i = 32'h0000_4444;
        mbi.mem_sel_i = 4'b0011; mbi.mem_data_i = 32'h1234_5678;
        repeat (3) tick();
        chk("pre_reset_req", mbi.bus_req_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        mbi.mem_ce_i = 1'b0;
        delay_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        repeat (6) tick();
        mem_txn(1'b0, 32'h0000_5000, 4'hf, 32'h0, 1'b0);
        repeat (2) tick();

        // Randomised traffic
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                if_txn($urandom & 32'hffff_fffc, $urandom_range(0, 7) == 0);
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                mem_txn(1'(($urandom_range(0, 1))), $urandom, 4'($urandom_range(1, 15)), $urandom,
                        $urandom_range(0, 7) == 0);
            end
        join
        repeat (5) tick();
        chk("if_q_empty", if_q.size(), 0);
        chk("mem_q_empty", mem_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
